// File: rtl/ram_wb_buffer_if.sv
// Signal bundle for ram_wb_buffer: command port, MXU result port, RAM write port, status.
// slave is the buffer's view of the bundle; master is the view of whoever drives it.
interface ram_wb_buffer_if;
    logic         ctrl_wb_vld;
    logic         ctrl_wb_rdy;
    logic [7:0]   ctrl_wb_start_addr;
    logic [3:0]   ctrl_wb_ent_num;
    logic         ctrl_wb_dir;

    logic [15:0]  mxu_wb_vld;
    logic [127:0] mxu_wb_data;
    logic         mxu_wb_last;
    logic         mxu_wb_rdy;

    logic         ram_write_vld;
    logic [7:0]   ram_write_addr;
    logic [127:0] ram_write_data;
    logic [15:0]  ram_write_strb;
    logic         ram_write_rdy;

    logic         wb_busy;
    logic         wb_done;

    modport slave (
        input  ctrl_wb_vld, ctrl_wb_start_addr, ctrl_wb_ent_num, ctrl_wb_dir,
        input  mxu_wb_vld, mxu_wb_data, mxu_wb_last,
        input  ram_write_rdy,
        output ctrl_wb_rdy, mxu_wb_rdy,
        output ram_write_vld, ram_write_addr, ram_write_data, ram_write_strb,
        output wb_busy, wb_done
    );

    modport master (
        output ctrl_wb_vld, ctrl_wb_start_addr, ctrl_wb_ent_num, ctrl_wb_dir,
        output mxu_wb_vld, mxu_wb_data, mxu_wb_last,
        output ram_write_rdy,
        input  ctrl_wb_rdy, mxu_wb_rdy,
        input  ram_write_vld, ram_write_addr, ram_write_data, ram_write_strb,
        input  wb_busy, wb_done
    );
endinterface

// File: rtl/ram_wb_buffer.sv
// Write-back buffer from the MXU to on-chip RAM. Byte-lane-valid result beats are merged
// into 16-byte lines; closed lines queue in a small FIFO and leave as strobed RAM writes
// whose line address walks up or down from the programmed start address.
module ram_wb_buffer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_BYTES = 16
) (
    input  logic           clk,
    input  logic           rst,
    ram_wb_buffer_if.slave wb
);
    localparam int DATA_W = LINE_BYTES * 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [7:0]            addr;
        logic [DATA_W-1:0]     data;
        logic [LINE_BYTES-1:0] strb;
    } line_t;

    state_t state, state_nxt;

    // Registered command fields and per-transfer progress
    logic [7:0] cmd_start_addr;
    logic [3:0] cmd_ent_num;
    logic       cmd_dir;
    logic [3:0] line_cnt;
    logic [7:0] addr_offset;

    // Line under assembly and its merge with the incoming beat
    logic [DATA_W-1:0]     asm_data;
    logic [LINE_BYTES-1:0] asm_strb;
    logic [DATA_W-1:0]     merged_data;
    logic [LINE_BYTES-1:0] merged_strb;

    // Closed-line FIFO
    line_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    line_t            push_line;
    line_t            head;

    logic fifo_empty;
    logic fifo_full;
    logic cmd_accept;
    logic beat_accept;
    logic line_close;
    logic last_line;
    logic push;
    logic pop;
    logic mxu_rdy;

    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign cmd_accept  = (state == IDLE) && wb.ctrl_wb_vld;
    assign beat_accept = (|wb.mxu_wb_vld) && mxu_rdy;
    assign merged_strb = asm_strb | wb.mxu_wb_vld;
    assign line_close  = beat_accept && ((merged_strb == '1) || wb.mxu_wb_last);
    assign last_line   = (line_cnt == cmd_ent_num);
    assign push        = line_close;
    assign pop         = !fifo_empty && wb.ram_write_rdy;
    assign wb.mxu_wb_rdy = mxu_rdy;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so no path through this block leaves a variable unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (wb.ctrl_wb_vld)          state_nxt = COLLECT;
            COLLECT: if (line_close && last_line) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty)              state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // FSM outputs; mxu_rdy depends only on registered state, never on ram_write_rdy
    always_comb begin
        wb.ctrl_wb_rdy = 1'b0;
        wb.wb_busy     = 1'b1;
        wb.wb_done     = 1'b0;
        mxu_rdy        = 1'b0;
        case (state)
            IDLE: begin
                wb.ctrl_wb_rdy = 1'b1;
                wb.wb_busy     = 1'b0;
            end
            COLLECT: mxu_rdy    = !fifo_full;
            DRAIN:   wb.wb_done = fifo_empty;
            default: ;
        endcase
    end

    // Byte merge: valid lanes of the beat overwrite the assembly bytes
    always_comb begin
        merged_data = asm_data;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (wb.mxu_wb_vld[k]) merged_data[8*k +: 8] = wb.mxu_wb_data[8*k +: 8];
        end
    end

    // Command capture, line assembly, line counter and address offset
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_start_addr <= '0;
            cmd_ent_num    <= '0;
            cmd_dir        <= 1'b0;
            line_cnt       <= '0;
            addr_offset    <= '0;
            asm_data       <= '0;
            asm_strb       <= '0;
        end else if (cmd_accept) begin
            cmd_start_addr <= wb.ctrl_wb_start_addr;
            cmd_ent_num    <= wb.ctrl_wb_ent_num;
            cmd_dir        <= wb.ctrl_wb_dir;
            line_cnt       <= '0;
            addr_offset    <= '0;
            asm_data       <= '0;
            asm_strb       <= '0;
        end else if (line_close) begin
            asm_data    <= '0;
            asm_strb    <= '0;
            line_cnt    <= line_cnt + 4'd1;
            addr_offset <= cmd_dir ? addr_offset - 8'd1 : addr_offset + 8'd1;
        end else if (beat_accept) begin
            asm_data <= merged_data;
            asm_strb <= merged_strb;
        end
    end

    // Line entering the FIFO; the address wraps modulo 256 in both directions
    always_comb begin
        push_line.addr = cmd_start_addr + addr_offset;
        push_line.data = merged_data;
        push_line.strb = merged_strb;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; fifo_cnt alone says which entries are live.
        if (push) fifo_mem[wr_ptr] <= push_line;
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // RAM request: FIFO head while non-empty, all zero otherwise
    always_comb begin
        head              = fifo_mem[rd_ptr];
        wb.ram_write_vld  = !fifo_empty;
        wb.ram_write_addr = '0;
        wb.ram_write_data = '0;
        wb.ram_write_strb = '0;
        if (!fifo_empty) begin
            wb.ram_write_addr = head.addr;
            wb.ram_write_data = head.data;
            wb.ram_write_strb = head.strb;
        end
    end
endmodule
